// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Package  : seg7_pkg
// Summary  : Shared types, constants and helpers for the 7-segment scan
//            controller and its digit-mask sub-block.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Scan FSM: BLANK turns every digit off while the decoder settles on the
  // next code, SHOW drives the enable of the current digit.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Largest legal BCD code; anything above is flagged and never displayed.
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_valid_bcd(input logic [3:0] code);
    return (code <= BCD_MAX);
  endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_digit_mask.sv
`default_nettype none
// ============================================================================
// Module   : seg7_digit_mask
// Summary  : Combinational per-digit enable mask. A digit is masked off when
//            its code is not valid BCD, or when leading-zero blanking is on
//            and it is a leading zero (digit 0 is never zero-suppressed; a
//            decimal point on the digit or any higher digit keeps it lit).
// Revision : 1.0 - initial release
// ============================================================================
module seg7_digit_mask
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   en_mask
);

  // Running "everything from here upward is a blank zero" flag
  logic hi_zero;

  // Walk from the most significant digit down, tracking leading-zero status
  always_comb begin
    en_mask = '0;
    hi_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_zero    = hi_zero & (digits[4*i +: 4] == 4'd0) & ~dp[i];
      en_mask[i] = is_valid_bcd(digits[4*i +: 4]) & ~(lz_blank & (i != 0) & hi_zero);
    end
  end

endmodule : seg7_digit_mask
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Summary  : Time-multiplexed scan controller for a multi-digit 7-segment
//            display. Double-buffers the digit frame, steps through digits
//            with a blanking gap before each, applies leading-zero and
//            invalid-code suppression and flags invalid frames. All outputs
//            are registered and follow the scan state by one clock.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    dp_out,
  output logic                    frame_start,
  output logic                    err_invalid
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Frame buffers
  logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] active_digits_q, active_digits_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic                    err_invalid_q, err_invalid_d;
  logic                    frame_has_bad;

  // Registered outputs
  logic [3:0]              bcd_out_q, bcd_out_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    dp_out_q, dp_out_d;
  logic                    frame_start_q, frame_start_d;

  logic [NUM_DIGITS-1:0]   en_mask;
  logic                    frame_end;

  // Last SHOW cycle of the last digit: the active frame may be swapped here
  assign frame_end = (state_q == SHOW) && (idx_q == IDX_LAST) && (cnt_q == SHOW_LAST);

  seg7_digit_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_digit_mask (
    .digits   (active_digits_q),
    .dp       (active_dp_q),
    .lz_blank (lz_blank),
    .en_mask  (en_mask)
  );

  // State register: scan FSM, frame buffers and output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= BLANK;
      idx_q           <= '0;
      cnt_q           <= '0;
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
      pending_q       <= 1'b0;
      active_digits_q <= '0;
      active_dp_q     <= '0;
      err_invalid_q   <= 1'b0;
      bcd_out_q       <= '0;
      digit_en_q      <= '0;
      dp_out_q        <= 1'b0;
      frame_start_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      pending_q       <= pending_d;
      active_digits_q <= active_digits_d;
      active_dp_q     <= active_dp_d;
      err_invalid_q   <= err_invalid_d;
      bcd_out_q       <= bcd_out_d;
      digit_en_q      <= digit_en_d;
      dp_out_q        <= dp_out_d;
      frame_start_q   <= frame_start_d;
    end
  end

  // Next-state: count out the blanking gap, then the display time, then advance digit
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Double buffering: loads go to the shadow; the active frame changes only at frame end
  always_comb begin
    shadow_digits_d = shadow_digits_q;
    shadow_dp_d     = shadow_dp_q;
    pending_d       = pending_q;
    active_digits_d = active_digits_q;
    active_dp_d     = active_dp_q;
    err_invalid_d   = err_invalid_q;
    frame_has_bad   = 1'b0;
    if (load) begin
      shadow_digits_d = digits_in;
      shadow_dp_d     = dp_in;
      pending_d       = 1'b1;
    end
    if (frame_end && (load || pending_q)) begin
      // A load landing on the boundary itself bypasses the shadow
      active_digits_d = load ? digits_in : shadow_digits_q;
      active_dp_d     = load ? dp_in     : shadow_dp_q;
      pending_d       = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!is_valid_bcd(active_digits_d[4*i +: 4])) begin
          frame_has_bad = 1'b1;
        end
      end
      err_invalid_d = frame_has_bad;
    end
  end

  // Output decode: code always follows the current digit, enable only in SHOW
  always_comb begin
    bcd_out_d     = active_digits_q[{idx_q, 2'b00} +: 4];
    digit_en_d    = '0;
    dp_out_d      = 1'b0;
    frame_start_d = (state_q == BLANK) && (idx_q == '0) && (cnt_q == '0);
    if ((state_q == SHOW) && en_mask[idx_q]) begin
      digit_en_d[idx_q] = 1'b1;
      dp_out_d          = active_dp_q[idx_q];
    end
  end

  assign bcd_out     = bcd_out_q;
  assign digit_en    = digit_en_q;
  assign dp_out      = dp_out_q;
  assign frame_start = frame_start_q;
  assign err_invalid = err_invalid_q;

endmodule : seg7_scan_ctrl
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Summary  : Scoreboard bench for seg7_scan_ctrl (4 digits, 4-cycle refresh,
//            1-cycle blank: 5-cycle slots, 20-cycle frames). The driver
//            pushes the hand-computed expected content of each upcoming
//            frame; the monitor pops one entry at every frame_start and
//            checks all 20 output cycles of that frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int FRAME = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_blank = 1'b0;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_en;
  logic        dp_out;
  logic        frame_start;
  logic        err_invalid;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        err;
  } frame_t;

  frame_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .lz_blank    (lz_blank),
    .bcd_out     (bcd_out),
    .digit_en    (digit_en),
    .dp_out      (dp_out),
    .frame_start (frame_start),
    .err_invalid (err_invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_bcd_out",     32'(bcd_out),     32'h0);
    check("rst_digit_en",    32'(digit_en),    32'h0);
    check("rst_dp_out",      32'(dp_out),      32'h0);
    check("rst_frame_start", 32'(frame_start), 32'h0);
    check("rst_err_invalid", 32'(err_invalid), 32'h0);
  endtask

  // Runs one frame starting at its frame_start negedge. Up to two loads at
  // given cycles, optional reset at cycle rc (returns right after asserting
  // it), and optionally pushes the expectation for the following frame.
  task automatic do_frame(input bit lz, input int c1, input logic [15:0] d1,
                          input logic [3:0] p1, input int c2, input logic [15:0] d2,
                          input int rc, input bit push, input logic [15:0] ed,
                          input logic [3:0] edp, input logic [3:0] een, input bit eerr);
    frame_t f;
    if (push) begin
      f.digits = ed;
      f.dp     = edp;
      f.en     = een;
      f.err    = eerr;
      sb.push_back(f);
    end
    lz_blank = lz;
    for (int c = 0; c < FRAME; c++) begin
      load = 1'b0;
      if (c == c1) begin
        load = 1'b1; digits_in = d1; dp_in = p1;
      end
      if (c == c2) begin
        load = 1'b1; digits_in = d2; dp_in = 4'b0000;
      end
      if (c == rc) begin
        rst = 1'b1;
        return;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  // Monitor: check each frame for which an expectation is queued
  initial begin : monitor
    frame_t e;
    int s, ph;
    logic [3:0] ee;
    logic       edp;
    forever begin
      @(negedge clk);
      if (!rst && frame_start && sb.size() > 0) begin
        e = sb.pop_front();
        for (int c = 0; c < FRAME; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) break;
          s   = c / 5;
          ph  = c % 5;
          ee  = 4'b0000;
          edp = 1'b0;
          if (ph != 0 && e.en[s]) begin
            ee[s] = 1'b1;
            edp   = e.dp[s];
          end
          check("mon_digit_en",    32'(digit_en),    32'(ee));
          check("mon_bcd_out",     32'(bcd_out),     32'(e.digits[4*s +: 4]));
          check("mon_dp_out",      32'(dp_out),      32'(edp));
          check("mon_frame_start", 32'(frame_start), 32'(c == 0));
          if (c == 0) check("mon_err_invalid", 32'(err_invalid), 32'(e.err));
        end
      end
    end
  end

  // Driver: directed frame-by-frame stimulus with hand-computed expectations
  initial begin : driver
    frame_t f0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    f0.digits = 16'h0000; f0.dp = 4'h0; f0.en = 4'b1111; f0.err = 1'b0;
    sb.push_back(f0);
    rst = 1'b0;
    @(negedge clk);
    check("first_frame_start", 32'(frame_start), 32'h1);

    //        lz  c1  d1        p1       c2  d2        rc  push  exp digits  dp       en       err
    do_frame(0,   5, 16'h1234, 4'b0000, -1, 16'h0000, -1, 1,    16'h1234, 4'b0000, 4'b1111, 0);
    do_frame(1,   5, 16'h0007, 4'b0000, -1, 16'h0000, -1, 1,    16'h0007, 4'b0000, 4'b0001, 0);
    do_frame(1,  -1, 16'h0000, 4'b0000, -1, 16'h0000, -1, 1,    16'h0007, 4'b0000, 4'b1111, 0);
    do_frame(0,   5, 16'h0045, 4'b0100, -1, 16'h0000, -1, 1,    16'h0045, 4'b0100, 4'b0111, 0);
    do_frame(1,   5, 16'h1A23, 4'b0000, -1, 16'h0000, -1, 1,    16'h1A23, 4'b0000, 4'b1011, 1);
    do_frame(1,  -1, 16'h0000, 4'b0000, -1, 16'h0000, -1, 1,    16'h1A23, 4'b0000, 4'b1011, 1);
    do_frame(1,   5, 16'h0123, 4'b0000, -1, 16'h0000, -1, 1,    16'h0123, 4'b0000, 4'b0111, 0);
    do_frame(1,   5, 16'h5555, 4'b0000, -1, 16'h0000, -1, 1,    16'h5555, 4'b0000, 4'b1111, 0);
    do_frame(0,  18, 16'h9876, 4'b0000, -1, 16'h0000, -1, 1,    16'h9876, 4'b0000, 4'b1111, 0);
    do_frame(0,  19, 16'h4321, 4'b0000, -1, 16'h0000, -1, 1,    16'h9876, 4'b0000, 4'b1111, 0);
    do_frame(0,   3, 16'h1111, 4'b0000,  8, 16'h12A2, -1, 1,    16'h12A2, 4'b0000, 4'b1101, 1);
    do_frame(0,   5, 16'h7777, 4'b0000, -1, 16'h0000, 12, 0,    16'h0000, 4'b0000, 4'b0000, 0);

    // Reset asserted during SHOW of slot 2: outputs must be at reset values next cycle
    load = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    f0.digits = 16'h0000; f0.dp = 4'h0; f0.en = 4'b1111; f0.err = 1'b0;
    sb.push_back(f0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_frame_start", 32'(frame_start), 32'h1);
    // Pending 7777 was discarded by reset, so the next frame stays zero too
    do_frame(0,  -1, 16'h0000, 4'b0000, -1, 16'h0000, -1, 1,    16'h0000, 4'b0000, 4'b1111, 0);

    repeat (FRAME + 1) @(negedge clk);
    check("all_frames_seen", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Bound the run in case the DUT or bench stalls
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_seg7_scan_ctrl
`default_nettype wire
